// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: counter encodings,
// indexing modes and saturating counter helpers.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int BP_BIMODAL = 0;
  localparam int BP_GSHARE  = 1;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    if (c == ST) begin
      return ST;
    end else begin
      return c + 2'd1;
    end
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    if (c == SNT) begin
      return SNT;
    end else begin
      return c - 2'd1;
    end
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: flop array of 2-bit counters with one registered
// read port, one training write port and a write-first read bypass.
module bp_pht
  import bp_pkg::*;
#(
  parameter int         IDX_W   = 10,
  parameter logic [1:0] CNT_RST = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_take,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_take
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0] cnt_r [DEPTH];
  logic [1:0] wr_val_s;
  logic       bypass_s;

  // Next counter value for the entry being trained, and same-index detection.
  always_comb begin
    wr_val_s = wr_take ? sat_inc(cnt_r[wr_idx]) : sat_dec(cnt_r[wr_idx]);
    bypass_s = wr_en && (wr_idx == rd_idx);
  end

  // Counter storage and registered read; a colliding write is forwarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i] <= CNT_RST;
      end
      rd_take <= 1'b0;
    end else begin
      if (wr_en) begin
        cnt_r[wr_idx] <= wr_val_s;
      end
      if (!hold) begin
        rd_take <= bypass_s ? wr_val_s[1] : cnt_r[rd_idx][1];
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor top: bimodal/gshare index hashing, committed
// global history, PHT instance and saturating debug statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         IDX_W   = 10,
  parameter int         GHR_W   = 8,
  parameter int         MODE    = BP_GSHARE,
  parameter logic [1:0] CNT_RST = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_f,
  input  logic             stall_d,
  output logic             pred_take_d,
  output logic [IDX_W-1:0] pred_idx_d,
  input  logic             update_en_m,
  input  logic [IDX_W-1:0] update_idx_m,
  input  logic             actual_take_m,
  input  logic             mispredict_m,
  output logic [GHR_W-1:0] ghr_o,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
);

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [GHR_W-1:0] ghr_r;
  logic [GHR_W-1:0] ghr_next_s;
  logic [IDX_W-1:0] base_s;
  logic [IDX_W-1:0] ghr_ext_s;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] pred_idx_r;
  logic [31:0]      stat_br_r;
  logic [31:0]      stat_mp_r;
  logic             unused_pc_s;

  assign unused_pc_s = ^{pc_f[31:IDX_W+2], pc_f[1:0]};

  // Lookup index always uses the committed (pre-update) history.
  always_comb begin
    base_s     = pc_f[IDX_W+1:2];
    ghr_ext_s  = IDX_W'(ghr_r);
    ghr_next_s = GHR_W'({ghr_r, actual_take_m});
    if (MODE == BP_GSHARE) begin
      idx_s = base_s ^ ghr_ext_s;
    end else begin
      idx_s = base_s;
    end
  end

  // History, statistics and the decode-aligned index register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_r      <= '0;
      stat_br_r  <= 32'd0;
      stat_mp_r  <= 32'd0;
      pred_idx_r <= '0;
    end else begin
      if (update_en_m) begin
        ghr_r <= ghr_next_s;
        if (stat_br_r != STAT_MAX) begin
          stat_br_r <= stat_br_r + 32'd1;
        end
        if (mispredict_m && (stat_mp_r != STAT_MAX)) begin
          stat_mp_r <= stat_mp_r + 32'd1;
        end
      end
      if (!stall_d) begin
        pred_idx_r <= idx_s;
      end
    end
  end

  bp_pht #(
    .IDX_W   (IDX_W),
    .CNT_RST (CNT_RST)
  ) u_pht (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall_d),
    .rd_idx  (idx_s),
    .rd_take (pred_take_d),
    .wr_en   (update_en_m),
    .wr_idx  (update_idx_m),
    .wr_take (actual_take_m)
  );

  assign pred_idx_d       = pred_idx_r;
  assign ghr_o            = ghr_r;
  assign stat_branches    = stat_br_r;
  assign stat_mispredicts = stat_mp_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: one bimodal and one gshare instance share the stimulus;
// every expected value is hand-computed.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        stall_d;
  logic        update_en_m;
  logic [9:0]  update_idx_m;
  logic        actual_take_m;
  logic        mispredict_m;

  logic        bi_take, gs_take;
  logic [9:0]  bi_idx, gs_idx;
  logic [7:0]  bi_ghr, gs_ghr;
  logic [31:0] bi_br, bi_mp, gs_br, gs_mp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(10), .GHR_W(8), .MODE(0), .CNT_RST(2'b01)) dut_bi (
    .clk(clk), .rst(rst), .pc_f(pc_f), .stall_d(stall_d),
    .pred_take_d(bi_take), .pred_idx_d(bi_idx),
    .update_en_m(update_en_m), .update_idx_m(update_idx_m),
    .actual_take_m(actual_take_m), .mispredict_m(mispredict_m),
    .ghr_o(bi_ghr), .stat_branches(bi_br), .stat_mispredicts(bi_mp)
  );

  branch_predictor #(.IDX_W(10), .GHR_W(8), .MODE(1), .CNT_RST(2'b01)) dut_gs (
    .clk(clk), .rst(rst), .pc_f(pc_f), .stall_d(stall_d),
    .pred_take_d(gs_take), .pred_idx_d(gs_idx),
    .update_en_m(update_en_m), .update_idx_m(update_idx_m),
    .actual_take_m(actual_take_m), .mispredict_m(mispredict_m),
    .ghr_o(gs_ghr), .stat_branches(gs_br), .stat_mispredicts(gs_mp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [9:0] idx, input logic take, input logic mis);
    update_en_m   = 1'b1;
    update_idx_m  = idx;
    actual_take_m = take;
    mispredict_m  = mis;
  endtask

  task automatic no_upd();
    update_en_m   = 1'b0;
    actual_take_m = 1'b0;
    mispredict_m  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'h0000_0010; stall_d = 1'b0;
    update_idx_m = 10'h000;
    no_upd();

    // Reset state and first lookup
    do_reset();
    chk("rst_take", 32'(bi_take), 32'd0);
    chk("rst_idx", 32'(bi_idx), 32'd0);
    chk("rst_ghr", 32'(gs_ghr), 32'd0);
    chk("rst_br", bi_br, 32'd0);
    chk("rst_mp", bi_mp, 32'd0);
    step();
    chk("look_idx", 32'(bi_idx), 32'h004);
    chk("look_take", 32'(bi_take), 32'd0);
    chk("look_gs_idx", 32'(gs_idx), 32'h004);

    // Train 01->10->11 then down to 00 and once more (must not wrap)
    pc_f = 32'h0000_0100;
    upd(10'h004, 1'b1, 1'b0); step(); step();
    no_upd(); pc_f = 32'h0000_0010; step();
    chk("trained_take", 32'(bi_take), 32'd1);
    chk("trained_ghr", 32'(bi_ghr), 32'h03);
    pc_f = 32'h0000_0100;
    upd(10'h004, 1'b0, 1'b0); step(); step(); step();
    no_upd(); pc_f = 32'h0000_0010; step();
    chk("untrained_take", 32'(bi_take), 32'd0);
    chk("br_five", bi_br, 32'd5);
    pc_f = 32'h0000_0100;
    upd(10'h004, 1'b0, 1'b0); step();
    no_upd(); pc_f = 32'h0000_0010; step();
    chk("sat_low_take", 32'(bi_take), 32'd0);
    chk("br_six", bi_br, 32'd6);
    chk("ghr_shift", 32'(bi_ghr), 32'h30);

    // gshare history and index hashing
    do_reset();
    pc_f = 32'h0000_0100;
    upd(10'h3FF, 1'b1, 1'b0); step(); step();
    upd(10'h3FF, 1'b0, 1'b0); step();
    chk("gs_ghr_110", 32'(gs_ghr), 32'h06);
    pc_f = 32'h0000_0010;
    upd(10'h3FF, 1'b1, 1'b0); step();
    chk("gs_idx_preupd", 32'(gs_idx), 32'h002);
    chk("bi_idx_nohash", 32'(bi_idx), 32'h004);
    chk("gs_take_002", 32'(gs_take), 32'd0);
    chk("gs_ghr_1101", 32'(gs_ghr), 32'h0D);
    no_upd();

    // Write-first bypass, then stall hold while updates continue
    do_reset();
    pc_f = 32'h0000_0010;
    upd(10'h004, 1'b1, 1'b0); step();
    chk("bypass_take", 32'(bi_take), 32'd1);
    chk("bypass_idx", 32'(bi_idx), 32'h004);
    stall_d = 1'b1;
    upd(10'h080, 1'b1, 1'b0); pc_f = 32'h0000_0200; step();
    chk("stall1_idx", 32'(bi_idx), 32'h004);
    chk("stall1_take", 32'(bi_take), 32'd1);
    pc_f = 32'h0000_0300; step();
    chk("stall2_idx", 32'(bi_idx), 32'h004);
    chk("stall2_take", 32'(bi_take), 32'd1);
    no_upd(); pc_f = 32'h0000_0400; step();
    chk("stall3_idx", 32'(bi_idx), 32'h004);
    chk("stall3_take", 32'(bi_take), 32'd1);
    stall_d = 1'b0; pc_f = 32'h0000_0200; step();
    chk("stall_upd_idx", 32'(bi_idx), 32'h080);
    chk("stall_upd_take", 32'(bi_take), 32'd1);

    // Statistics and saturation
    do_reset();
    pc_f = 32'h0000_0100;
    upd(10'h010, 1'b1, 1'b1); step();
    upd(10'h010, 1'b1, 1'b0); step();
    upd(10'h010, 1'b0, 1'b1); step();
    upd(10'h010, 1'b0, 1'b0); step();
    no_upd(); mispredict_m = 1'b1; step();
    chk("stat_br4", bi_br, 32'd4);
    chk("stat_mp2", bi_mp, 32'd2);
    mispredict_m = 1'b0;
    force dut_bi.stat_br_r = 32'hFFFF_FFFF;
    step();
    release dut_bi.stat_br_r;
    upd(10'h010, 1'b1, 1'b0); step();
    no_upd();
    chk("stat_br_sat", bi_br, 32'hFFFF_FFFF);
    chk("stat_mp_hold", bi_mp, 32'd2);
    chk("stat_gs_br5", gs_br, 32'd5);

    // Reset overrides a concurrent update
    pc_f = 32'h0000_0100;
    upd(10'h004, 1'b1, 1'b0); step();
    pc_f = 32'h0000_0010; step();
    chk("pre_rst_take", 32'(bi_take), 32'd1);
    rst = 1'b0; step();
    rst = 1'b1; no_upd();
    chk("rst2_take", 32'(bi_take), 32'd0);
    chk("rst2_idx", 32'(bi_idx), 32'd0);
    chk("rst2_ghr", 32'(gs_ghr), 32'd0);
    chk("rst2_br", bi_br, 32'd0);
    chk("rst2_mp", bi_mp, 32'd0);
    step();
    chk("post_rst_idx", 32'(bi_idx), 32'h004);
    chk("post_rst_take", 32'(bi_take), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. Replaces the static "branch resolved in decode" next-PC path.
- Looks up a pattern history table (PHT) of 2-bit saturating counters with the fetch PC. Delivers a registered taken/not-taken prediction plus the table index aligned with decode.
- Accepts the resolved outcome from the memory stage to train the table and the global history register (GHR).
- Selectable indexing mode (PC-indexed bimodal or gshare). Keeps branch and mispredict statistics for debug.

Parameters:
IDX_W, 10, PHT index width; table holds 2**IDX_W counters
GHR_W, 8, global history length in bits; legal range 1..IDX_W
MODE, 1, 0 = bimodal (PC index only), 1 = gshare (PC index XOR history)
CNT_RST, 2'b01, counter reset value (weakly not-taken)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
pc_f  in  32  fetch-stage PC
stall_d  in  1  decode stall; hold all decode-aligned outputs
pred_take_d  out  1  prediction for the instruction now in decode
pred_idx_d  out  IDX_W  PHT index used for that prediction; the pipeline carries it to M
update_en_m  in  1  a conditional branch is resolving in M this cycle
update_idx_m  in  IDX_W  index carried down the pipe with that branch
actual_take_m  in  1  resolved direction
mispredict_m  in  1  resolved direction differed from prediction
ghr_o  out  GHR_W  current committed global history
stat_branches  out  32  count of update_en_m cycles, saturating
stat_mispredicts  out  32  count of update_en_m & mispredict_m cycles, saturating

Behaviour:
- Reset (rst==0 at a rising edge): all PHT counters = CNT_RST; GHR = 0; pred_take_d = 0; pred_idx_d = 0; both stat counters = 0. Reset is one cycle; the first lookup after release is valid. Reset overrides any concurrent update.
- Index function:
  - base = pc_f[IDX_W+1:2].
  - MODE 0: idx = base.
  - MODE 1: idx = base XOR {zeros, GHR}, with GHR zero-extended to IDX_W.
- Lookup latency is 1 cycle:
  - At each rising edge with stall_d==0: pred_idx_d <= idx; pred_take_d <= counter(idx)[1].
  - With stall_d==1 both outputs hold.
- Update at a rising edge with update_en_m==1:
  - counter(update_idx_m) saturating-increments if actual_take_m (max 3), else saturating-decrements (min 0).
  - GHR <= {GHR[GHR_W-2:0], actual_take_m}. For GHR_W==1, GHR <= actual_take_m.
- GHR is committed-only. It is not speculatively updated at lookup, so no repair on flush is needed.
- Lookup idx in a cycle always uses the pre-update GHR.
- Same-index read/write in the same cycle (lookup idx == update_idx_m, update_en_m==1, stall_d==0): pred_take_d takes bit[1] of the post-update counter (write-first bypass).
- update_en_m==0: PHT, GHR and stat counters hold. mispredict_m is ignored.
- Stats:
  - stat_branches += 1 per update.
  - stat_mispredicts += 1 when update_en_m & mispredict_m.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- stall_d has no effect on updates. Updates proceed during a decode stall.
- PHT is implemented as a flop array, not block RAM, so that the synchronous reset is one cycle.

Decomposition:
- Shared package bp_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the sat_inc/sat_dec functions;
  - MODE constants BP_BIMODAL=0, BP_GSHARE=1.
- One natural sub-module, bp_pht: counter array with one registered read port, one write port and the bypass. Index hashing, GHR and stats stay in branch_predictor.

Test Plan:
- Reset then lookup pc_f=32'h0000_0010 with MODE=0, IDX_W=10 -> next cycle pred_idx_d=10'h004, pred_take_d=0. ghr_o=0, both stats=0.
- Two taken updates at idx 10'h004 -> counter 01->10->11; lookup pc_f=32'h0000_0010 -> pred_take_d=1. Then three not-taken updates -> counter 00 (saturates, no wrap), pred_take_d=0, stat_branches=5.
- MODE=1, GHR_W=8: updates taken, taken, not-taken -> ghr_o=8'b0000_0110. Lookup pc_f=32'h0000_0010 -> pred_idx_d=10'h004^10'h006=10'h002.
- Same-cycle update (idx 10'h004, taken, counter 01) and lookup of the same idx -> pred_take_d=1 (bypass). Hold stall_d=1 for 3 cycles while pc_f changes -> pred_idx_d/pred_take_d unchanged.
- 4 updates, 2 with mispredict_m=1, then mispredict_m=1 with update_en_m=0 -> stat_branches=4, stat_mispredicts=2. Force stat_branches to 32'hFFFF_FFFF and update -> stays 32'hFFFF_FFFF.
- Assert rst=0 in a cycle with update_en_m=1 after training -> all counters 01, ghr_o=0, stats=0, pred_take_d=0 the following cycle.
